// File: rtl/clock_divide_multi_if.sv
// clock_divide_multi_if: per-channel control and output bundle for the multi-channel divider
//   en      per-channel count enable          (master -> slave)
//   clr     per-channel synchronous restart   (master -> slave)
//   mode    0 = toggle, 1 = pulse             (master -> slave)
//   upto    packed terminal counts, CNT_W each (master -> slave)
//   div_out divided output                    (slave -> master)
//   tick    one-cycle wrap strobe             (slave -> master)
interface clock_divide_multi_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
);
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       mode;
    logic [NCH*CNT_W-1:0] upto;
    logic [NCH-1:0]       div_out;
    logic [NCH-1:0]       tick;
    modport master (output en, clr, mode, upto, input div_out, tick);
    modport slave  (input en, clr, mode, upto, output div_out, tick);
endinterface

// File: rtl/clock_divide_multi.sv
// clock_divide_multi: NCH-channel programmable divider producing square waves or one-cycle ticks
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset, overrides every other input
//   bus  slave side of clock_divide_multi_if (en/clr/mode/upto in, div_out/tick out)
module clock_divide_multi #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    clock_divide_multi_if.slave    bus
);
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            div_q, div_d, tick_q, tick_d, wrap;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = '0;
        wrap   = '0;
        for (int i = 0; i < NCH; i++) begin
            // >= rather than == so lowering upto below the count wraps at once
            wrap[i] = cnt_q[i] >= bus.upto[i*CNT_W +: CNT_W];
            if (bus.clr[i]) begin
                cnt_d[i] = '0;
                div_d[i] = 1'b0;
            end else if (!bus.en[i]) begin
                div_d[i] = bus.mode[i] ? 1'b0 : div_q[i];
            end else begin
                tick_d[i] = wrap[i];
                cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + 1'b1;
                div_d[i]  = bus.mode[i] ? wrap[i] : div_q[i] ^ wrap[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign bus.div_out = div_q;
    assign bus.tick    = tick_q;
endmodule
